// File: rtl/mor1kx_branch_predictor_gshare_pkg.sv
// Shared helpers for the gshare branch predictor:
// counter reset value, saturating step, parameter legality.
package mor1kx_branch_predictor_gshare_pkg;

  function automatic logic [31:0] cnt_reset_val(
    input int unsigned w
  );
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] sat_step(
    input logic [31:0] cnt,
    input logic        inc,
    input int unsigned w
  );
    logic [31:0] max;
    max = (32'd1 << w) - 32'd1;
    if (inc) return (cnt == max) ? cnt : cnt + 32'd1;
    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

  function automatic bit params_legal(
    input int unsigned iw,
    input int unsigned hw,
    input int unsigned cw
  );
    return (iw >= 1) && (hw >= 1) && (hw <= iw) &&
           (cw >= 1) && (cw <= 31);
  endfunction

endpackage

// File: rtl/mor1kx_bp_sat_counter.sv
// One pattern-history-table entry: a saturating
// up/down counter that resets to weakly taken.
module mor1kx_bp_sat_counter
  import mor1kx_branch_predictor_gshare_pkg::*;
#(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 msb_o
);

  localparam logic [CNT_WIDTH-1:0] RST_VAL =
    CNT_WIDTH'(cnt_reset_val(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en)
      count_d = CNT_WIDTH'(
        sat_step(32'(count_q), inc, CNT_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= RST_VAL;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign msb_o   = count_q[CNT_WIDTH-1];

endmodule

// File: rtl/mor1kx_branch_predictor_gshare.sv
// Table-based conditional branch predictor (gshare or
// bimodal) with non-speculative global history.
module mor1kx_branch_predictor_gshare
  import mor1kx_branch_predictor_gshare_pkg::*;
#(
  parameter int PC_WIDTH      = 32,
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 6,
  parameter int CNT_WIDTH     = 2,
  parameter int GSHARE        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PC_WIDTH-1:0]      decode_pc_i,
  input  logic                     op_bf_i,
  input  logic                     op_bnf_i,
  input  logic                     padv_decode_i,
  output logic                     predicted_flag_o,
  input  logic                     execute_op_bf_i,
  input  logic                     execute_op_bnf_i,
  input  logic                     flag_i,
  input  logic                     prev_op_brcond_i,
  input  logic                     branch_mispredict_i,
  output logic [HISTORY_WIDTH-1:0] ghr_o,
  output logic [31:0]              mispredict_count_o
);

  localparam int N = 1 << INDEX_WIDTH;

  if (!params_legal(INDEX_WIDTH, HISTORY_WIDTH,
                    CNT_WIDTH)) begin : g_bad_params
    $error("illegal predictor parameters");
  end

  logic [INDEX_WIDTH-1:0]   pred_idx;
  logic [INDEX_WIDTH-1:0]   exec_index_q, exec_index_d;
  logic [HISTORY_WIDTH-1:0] ghr_q, ghr_d;
  logic [31:0]              mis_cnt_q, mis_cnt_d;
  logic [N-1:0]             taken_vec;
  logic [CNT_WIDTH-1:0]     cnt_unused [N];
  logic                     upd, brn_taken, taken;

  always_comb begin
    pred_idx = decode_pc_i[INDEX_WIDTH+1:2];
    if (GSHARE != 0)
      pred_idx = pred_idx ^ INDEX_WIDTH'(ghr_q);
    taken = taken_vec[pred_idx];
    predicted_flag_o = (taken & op_bf_i) |
                       (~taken & op_bnf_i);
    upd = prev_op_brcond_i & padv_decode_i;
    brn_taken = (execute_op_bf_i & flag_i) |
                (execute_op_bnf_i & ~flag_i);
    exec_index_d = padv_decode_i ? pred_idx
                                 : exec_index_q;
    // History shifts only on resolution, never on prediction.
    ghr_d = upd ? HISTORY_WIDTH'({ghr_q, brn_taken})
                : ghr_q;
    mis_cnt_d = (upd & branch_mispredict_i)
              ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_index_q <= '0;
      ghr_q        <= '0;
      mis_cnt_q    <= '0;
    end else begin
      exec_index_q <= exec_index_d;
      ghr_q        <= ghr_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pht
    mor1kx_bp_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (upd && (exec_index_q == INDEX_WIDTH'(i))),
      .inc     (brn_taken),
      .count_o (cnt_unused[i]),
      .msb_o   (taken_vec[i])
    );
  end

  if (PC_WIDTH > INDEX_WIDTH + 2) begin : g_pc_hi
    logic pc_hi_unused;
    assign pc_hi_unused =
      ^decode_pc_i[PC_WIDTH-1:INDEX_WIDTH+2];
  end

  logic pc_lo_unused;
  assign pc_lo_unused = ^decode_pc_i[1:0];

  assign ghr_o              = ghr_q;
  assign mispredict_count_o = mis_cnt_q;

endmodule
